// File: rtl/circuit_vector_sequencer.sv
// Drives X/Y/Z of a three-input circuit through vectors 0..7, samples M at the end of each hold
// and compares it with the EXPECTED truth table, reporting a mismatch map, count and pass flag.
module circuit_vector_sequencer #(
    parameter int unsigned HOLD_CYCLES = 20,
    parameter logic [7:0]  EXPECTED    = 8'hE8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       m_in,
    output logic       x_out,
    output logic       y_out,
    output logic       z_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] err_vec
);

    localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

    state_e     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [2:0] xyz_q, xyz_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] err_vec_q, err_vec_d;
    logic [3:0] err_count_q, err_count_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            vec_q       <= 3'd0;
            xyz_q       <= 3'd0;
            cnt_q       <= 8'd0;
            err_vec_q   <= 8'd0;
            err_count_q <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            xyz_q       <= xyz_d;
            cnt_q       <= cnt_d;
            err_vec_q   <= err_vec_d;
            err_count_q <= err_count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        xyz_d       = xyz_q;
        cnt_d       = cnt_q;
        err_vec_d   = err_vec_q;
        err_count_d = err_count_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StDrive;
                    vec_d       = 3'd0;
                    xyz_d       = 3'd0;
                    cnt_d       = 8'd0;
                    err_vec_d   = 8'd0;
                    err_count_d = 4'd0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                end
            end
            StDrive: begin
                if (cnt_q < HoldLast) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    if (m_in != EXPECTED[vec_q]) begin
                        err_vec_d[vec_q] = 1'b1;
                        err_count_d      = err_count_q + 4'd1;
                    end
                    cnt_d = 8'd0;
                    if (vec_q != 3'd7) begin
                        vec_d = vec_q + 3'd1;
                        xyz_d = vec_q + 3'd1;
                    end else begin
                        // pass must see this edge's comparison, so it uses the next count
                        state_d = StDone;
                        vec_d   = 3'd0;
                        xyz_d   = 3'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_count_d == 4'd0);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign x_out     = xyz_q[2];
    assign y_out     = xyz_q[1];
    assign z_out     = xyz_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign err_vec   = err_vec_q;

endmodule

// File: tb/tb_circuit_vector_sequencer.sv
// Bench for circuit_vector_sequencer: an emulated circuit with injectable faults, a behavioural
// timing model compared every cycle, plus directed and randomized sweep checks.
module tb_circuit_vector_sequencer;

    localparam int         H   = 4;
    localparam logic [7:0] EXP = 8'hE8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       m_in;
    logic       x_out, y_out, z_out, busy, done, pass;
    logic [3:0] err_count;
    logic [7:0] err_vec;

    logic [7:0] mask = 8'h00;   // vectors whose M output is inverted by the emulated circuit
    logic [2:0] idx;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    circuit_vector_sequencer #(
        .HOLD_CYCLES(H),
        .EXPECTED   (EXP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .m_in     (m_in),
        .x_out    (x_out),
        .y_out    (y_out),
        .z_out    (z_out),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .err_vec  (err_vec)
    );

    assign idx  = {x_out, y_out, z_out};
    assign m_in = EXP[idx] ^ mask[idx];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Behavioural model: position in the sweep as a plain cycle offset from the accepting edge.
    logic       m_busy, m_done;
    logic [7:0] m_errs;
    int         m_t;

    always @(posedge clk or posedge rst) begin
        int         v;
        logic [7:0] e;
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_errs <= 8'h00;
            m_t    <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_done <= 1'b0;
                m_errs <= 8'h00;
                m_t    <= 0;
            end
        end else begin
            v = m_t / H;
            if ((m_t + 1) % H == 0) begin
                e = m_errs;
                if (m_in != EXP[v]) e[v] = 1'b1;
                m_errs <= e;
                if (v == 7) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        logic [2:0] exyz;
        logic       epass;
        exyz  = m_busy ? 3'(m_t / H) : 3'd0;
        epass = m_done && (m_errs == 8'h00);
        check("cycle_outputs",
              {13'd0, x_out, y_out, z_out, busy, done, pass, err_count, err_vec},
              {13'd0, exyz, m_busy, m_done, epass, 4'($countones(m_errs)), m_errs});
    end

    task automatic do_start(output int e0);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        e0 = cyc;
    endtask

    // Runs one sweep; returns busy cycle count, start-to-done latency and flags seen after E0.
    task automatic run_sweep(input logic [7:0] m, input int pulse_at,
                             output int bc, output int lat, output logic [15:0] first);
        int e0;
        mask = m;
        do_start(e0);
        bc   = 0;
        lat  = -1;
        first = {2'b00, done, pass, err_count, err_vec};
        for (int i = 0; i < 400; i++) begin
            start = (i == pulse_at);
            if (busy) bc++;
            if (done) begin
                lat = cyc - e0;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    initial begin
        int          bc, lat;
        logic [15:0] first;
        logic [7:0]  rm;

        // Reset held with start high
        #1 rst = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {x_out, y_out, z_out, busy, done, pass, err_count, err_vec}, 0);
        start = 1'b0;
        rst   = 1'b0;
        repeat (5) @(posedge clk);
        #2 check("idle_after_reset", {x_out, y_out, z_out, busy}, 0);

        // Golden circuit
        run_sweep(8'h00, -1, bc, lat, first);
        check("golden_busy_cycles", bc, 32);
        check("golden_latency", lat, 32);
        check("golden_result", {done, pass, err_count, err_vec}, {1'b1, 1'b1, 4'd0, 8'h00});

        // M tied low, with an ignored start pulse mid-sweep
        run_sweep(EXP, 10, bc, lat, first);
        check("tied0_latency", lat, 32);
        check("tied0_result", {done, pass, err_count, err_vec}, {1'b1, 1'b0, 4'd4, 8'hE8});

        // Restart from DONE clears flags on the accepting edge
        run_sweep(8'h80, -1, bc, lat, first);
        check("restart_flags_clear", first, {2'b00, 1'b0, 1'b0, 4'd0, 8'h00});
        check("vec7_latency", lat, 32);
        check("vec7_result", {done, pass, err_count, err_vec}, {1'b1, 1'b0, 4'd1, 8'h80});

        // Asynchronous reset while vector 3 is driven
        mask = 8'h00;
        do_start(bc);
        for (int i = 0; i < 100; i++) begin
            if (idx == 3'd3) break;
            @(posedge clk);
            #1;
        end
        check("reached_vec3", idx, 3);
        #2 rst = 1'b1;
        #1 check("async_reset", {x_out, y_out, z_out, busy, done, pass, err_count, err_vec}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_sweep(8'h00, -1, bc, lat, first);
        check("post_reset_sweep", {lat[7:0], done, pass, err_count, err_vec},
              {8'd32, 1'b1, 1'b1, 4'd0, 8'h00});

        // Randomized fault maps and stray start pulses
        for (int s = 0; s < 6; s++) begin
            rm = 8'($urandom);
            run_sweep(rm, int'($urandom_range(0, 40)), bc, lat, first);
            check("rand_latency", lat, 32);
            check("rand_result", {done, pass, err_count, err_vec},
                  {1'b1, (rm == 8'h00), 4'($countones(rm)), rm});
        end

        repeat (3) @(posedge clk);
        #2 $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
